// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and defaults for the shift-and-add multiplier sequencer.
// The state encoding is fixed so that other tools can decode the register.
package mult_seq_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Operand, datapath and result handshake bundle between the issuer, the
// sequencer and the Data_Path.
interface mult_seq_ctrl_if
    import mult_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             iValid;
    logic             oReady;
    logic [WIDTH-1:0] iData_A;
    logic [WIDTH-1:0] iData_B;
    logic             iAbort;
    logic             oDataLoad;
    logic [WIDTH-1:0] oDp_A;
    logic [WIDTH-1:0] oDp_B;
    logic [WIDTH-1:0] iDpResult;
    logic             oValid;
    logic             iReady;
    logic [WIDTH-1:0] oResult;
    logic             oBusy;

    // Controller side.
    modport slave (
        input  iValid, iData_A, iData_B, iAbort, iDpResult, iReady,
        output oReady, oDataLoad, oDp_A, oDp_B, oValid, oResult, oBusy
    );

    // Issuer / datapath / consumer side.
    modport master (
        output iValid, iData_A, iData_B, iAbort, iDpResult, iReady,
        input  oReady, oDataLoad, oDp_A, oDp_B, oValid, oResult, oBusy
    );
endinterface

// File: rtl/mult_seq_ctrl_counter.sv
// Free-running up-counter with synchronous clear; used as the step counter
// of the multiplier sequencer.
module Counter #(
    parameter int SIZE = 5
) (
    input  logic            Clock,
    input  logic            iCounterReset,
    output logic [SIZE-1:0] oCounter
);

    always_ff @(posedge Clock) begin
        if (iCounterReset) begin
            oCounter <= '0;
        end else begin
            oCounter <= oCounter + SIZE'(1);
        end
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the shift-and-add Data_Path: accepts an operand pair, runs
// exactly WIDTH datapath steps, captures the product and holds it until taken.
module mult_seq_ctrl
    import mult_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic           Clock,
    input  logic           Reset,
    mult_seq_ctrl_if.slave bus
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] step_cnt;
    logic             step_last;
    logic             counter_reset;
    logic             accept;

    // Counter sits at zero everywhere except RUN, so RUN always starts from 0.
    assign counter_reset = Reset | (state != RUN);

    Counter #(
        .SIZE(CNT_W)
    ) u_counter (
        .Clock         (Clock),
        .iCounterReset (counter_reset),
        .oCounter      (step_cnt)
    );

    assign step_last = (step_cnt == CNT_W'(WIDTH - 1));
    assign accept    = (state == IDLE) && bus.iValid;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.iValid) state_next = LOAD;
            LOAD:    state_next = bus.iAbort ? IDLE : RUN;
            RUN: begin
                if (bus.iAbort) begin
                    state_next = IDLE;
                end else if (step_last) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: state_next = bus.iAbort ? IDLE : DONE;
            DONE:    if (bus.iReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture waits one cycle past RUN: the accumulator settles on the last RUN edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            data_a <= '0;
            data_b <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                data_a <= bus.iData_A;
                data_b <= bus.iData_B;
            end
            if ((state == CAPTURE) && !bus.iAbort) begin
                result <= bus.iDpResult;
            end
        end
    end

    assign bus.oReady    = (state == IDLE);
    assign bus.oDataLoad = (state == LOAD);
    assign bus.oBusy     = (state == LOAD) || (state == RUN) || (state == CAPTURE);
    assign bus.oValid    = (state == DONE);
    assign bus.oDp_A     = data_a;
    assign bus.oDp_B     = data_b;
    assign bus.oResult   = result;

endmodule
